tt_um_vend_dispenser: RTL and testbench
=======================================

TT_UM_VEND_DISPENSER -- requirements
Module: tt_um_vend_dispenser

Interface
REQ-001 Parameter: PULSE_CYCLES, default 8; number of cycles the actuator output is held high per dispense.
REQ-002 Parameter: TIMEOUT_CYCLES, default 64; maximum cycles to wait for the drop sensor after the drive phase.
REQ-003 clk  input  1  the single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  when 0, all registers hold their values.
REQ-006 ui_in  input  8  [0] prod_req pulse, [1] chg_req pulse, [2] prod_drop sensor, [3] coin_drop sensor, [4] fault_clr, [7:5] ignored.
REQ-007 uo_out  output  8  [0] prod_motor, [1] chg_solenoid, [2] busy, [3] fault, [4] overflow, [7:5] constant 0.
REQ-008 uio_in  input  8  unused.
REQ-009 uio_out  output  8  [1:0] prod_pend, [3:2] chg_pend, [7:4] constant 0.
REQ-010 uio_oe  output  8  constant 8'h0F.

Function
REQ-011 prod_req and chg_req are single-cycle request pulses, sampled directly with no synchronizer; each high cycle counts as one request.
REQ-012 prod_pend and chg_pend are 2-bit saturating counters: +1 on a request, -1 on a completed dispense of that kind, unchanged when both occur in the same cycle.
REQ-013 A request arriving while its counter is 3 is dropped and sets sticky overflow.
REQ-014 prod_drop and coin_drop each pass through a 2-flop synchronizer, then a rising-edge detector; only detected edges count.
REQ-015 FSM states: IDLE, PROD_DRIVE, PROD_WAIT, CHG_DRIVE, CHG_WAIT, FAULT.
REQ-016 IDLE: if prod_pend>0 go to PROD_DRIVE; else if chg_pend>0 go to CHG_DRIVE; product always has priority over change.
REQ-017 The actuator output is registered and high exactly while in *_DRIVE. The request pulse occurs in cycle n; the counter updates at edge n+1; the actuator first reads high in cycle n+2 when starting from IDLE.
REQ-018 *_DRIVE lasts exactly PULSE_CYCLES cycles, then the FSM moves to *_WAIT and the timeout counter is cleared.
REQ-019 A matching sensor edge during *_DRIVE is latched. *_WAIT then completes on its first cycle.
REQ-020 *_WAIT ends on a matching sensor edge (or latched edge): the pending counter of that kind is decremented and the FSM returns to IDLE.
REQ-021 Non-matching sensor edges are ignored in every state.
REQ-022 *_WAIT ends after TIMEOUT_CYCLES cycles with no matching edge: go to FAULT; the pending counter is not decremented.
REQ-023 FAULT: fault=1, both actuators 0, new requests are discarded and do not set overflow.
REQ-024 fault_clr (level, sampled in FAULT) clears both pending counters and overflow, then returns to IDLE. fault_clr is ignored outside FAULT.
REQ-025 busy=1 in any state other than IDLE.
REQ-026 The timeout counter has clog2(TIMEOUT_CYCLES)+1 bits. The drive counter has clog2(PULSE_CYCLES)+1 bits. Neither counter wraps.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, all counters and latches 0, synchronizer flops 0, and all outputs 0 except uio_oe=8'h0F.
REQ-028 Reset mid-dispense aborts immediately: actuator low in the same cycle that reset asserts, and pending requests are lost.

Structure
REQ-029 Package vend_pkg: the state enum, ui_in/uo_out bit-index constants, and default PULSE_CYCLES/TIMEOUT_CYCLES.
REQ-030 One sub-module vend_sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated twice.

Verification
REQ-031 One prod_req pulse, then a prod_drop edge 3 cycles into PROD_WAIT -> prod_motor high for 8 cycles starting 2 cycles after the request; prod_pend goes 1 then 0; busy drops; fault stays 0.
REQ-032 prod_req and chg_req in the same cycle, both sensors answered -> product dispense first, change dispense second; no overlap of uo_out[0] and uo_out[1].
REQ-033 Four prod_req pulses with no dispense completion -> prod_pend=3; overflow=1 after the 4th pulse.
REQ-034 chg_req with no coin_drop -> fault=1 exactly 64 cycles after CHG_WAIT entry; chg_pend stays 1; a later request is ignored; fault_clr returns to IDLE with pending=0 and overflow=0.
REQ-035 coin_drop edge during CHG_DRIVE -> FSM leaves CHG_WAIT in its first cycle; chg_pend is decremented.
REQ-036 rst_n pulsed low in cycle 4 of PROD_DRIVE -> prod_motor low immediately; all outputs at reset values; ena=0 freezes state and outputs.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispenser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROD_DRIVE,
    ST_PROD_WAIT,
    ST_CHG_DRIVE,
    ST_CHG_WAIT,
    ST_FAULT
  } state_t;

  // ui_in bit positions
  localparam int UI_PROD_REQ  = 0;
  localparam int UI_CHG_REQ   = 1;
  localparam int UI_PROD_DROP = 2;
  localparam int UI_COIN_DROP = 3;
  localparam int UI_FAULT_CLR = 4;

  // uo_out bit positions
  localparam int UO_PROD_MOTOR = 0;
  localparam int UO_CHG_SOL    = 1;
  localparam int UO_BUSY       = 2;
  localparam int UO_FAULT      = 3;
  localparam int UO_OVERFLOW   = 4;

  localparam int DEF_PULSE_CYCLES   = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Saturating 2-bit pending count: a request and a completion in the same
  // cycle cancel; a request at 3 is dropped (overflow is flagged by the caller).
  function automatic logic [1:0] pend_next(input logic [1:0] cur,
                                           input logic inc,
                                           input logic dec);
    logic [1:0] res;
    res = cur;
    if (inc && !dec && cur != 2'd3) res = cur + 2'd1;
    else if (dec && !inc && cur != 2'd0) res = cur - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/vend_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one sensor.
// Latency: edge pulse appears 2 cycles after the raw input rises.
// Backpressure: none; ena=0 freezes all flops.
module vend_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else if (ena) begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/tt_um_vend_dispenser.sv
// Vending dispenser: queues product/change requests and drives one actuator at a time.
// Latency: actuator rises 2 cycles after a request pulse when idle.
// Backpressure: up to 3 pending per kind; further requests dropped and flagged as overflow.
module tt_um_vend_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DRV_W = $clog2(PULSE_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t state, state_nxt;
  logic [DRV_W-1:0] drv_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic drop_seen;
  logic [1:0] prod_pend, chg_pend;
  logic overflow, prod_motor, chg_sol, busy, fault;
  logic prod_edge, coin_edge;
  logic prod_done, chg_done;
  logic drive_end, tmo_end, drive_match;

  logic prod_req, chg_req, fault_clr;
  assign prod_req  = ui_in[UI_PROD_REQ];
  assign chg_req   = ui_in[UI_CHG_REQ];
  assign fault_clr = ui_in[UI_FAULT_CLR];

  logic unused_in;
  assign unused_in = &{1'b0, uio_in, ui_in[7:5]};

  vend_sync_edge u_prod_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   (ui_in[UI_PROD_DROP]),
    .pulse (prod_edge)
  );

  vend_sync_edge u_coin_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   (ui_in[UI_COIN_DROP]),
    .pulse (coin_edge)
  );

  assign drive_end   = (drv_cnt == DRV_W'(PULSE_CYCLES - 1));
  assign tmo_end     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign drive_match = ((state == ST_PROD_DRIVE) && prod_edge) ||
                       ((state == ST_CHG_DRIVE)  && coin_edge);

  // Next-state decision; product always wins over change in IDLE
  always_comb begin
    state_nxt = state;
    prod_done = 1'b0;
    chg_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (prod_pend != 2'd0)     state_nxt = ST_PROD_DRIVE;
        else if (chg_pend != 2'd0) state_nxt = ST_CHG_DRIVE;
      end
      ST_PROD_DRIVE: if (drive_end) state_nxt = ST_PROD_WAIT;
      ST_PROD_WAIT: begin
        if (prod_edge || drop_seen) begin
          prod_done = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_end) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_CHG_DRIVE: if (drive_end) state_nxt = ST_CHG_WAIT;
      ST_CHG_WAIT: begin
        if (coin_edge || drop_seen) begin
          chg_done  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_end) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: if (fault_clr) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, phase counters, drop latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      drv_cnt    <= '0;
      tmo_cnt    <= '0;
      drop_seen  <= 1'b0;
      prod_motor <= 1'b0;
      chg_sol    <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else if (ena) begin
      state      <= state_nxt;
      prod_motor <= (state_nxt == ST_PROD_DRIVE);
      chg_sol    <= (state_nxt == ST_CHG_DRIVE);
      busy       <= (state_nxt != ST_IDLE);
      fault      <= (state_nxt == ST_FAULT);

      if (state == ST_IDLE) begin
        drv_cnt   <= '0;
        drop_seen <= 1'b0;
      end else if (state == ST_PROD_DRIVE || state == ST_CHG_DRIVE) begin
        if (!drive_end) drv_cnt <= drv_cnt + DRV_W'(1);
        if (drive_match) drop_seen <= 1'b1;
      end

      // Held at zero through the drive phase so every wait starts fresh
      if (state == ST_PROD_DRIVE || state == ST_CHG_DRIVE) begin
        tmo_cnt <= '0;
      end else if ((state == ST_PROD_WAIT || state == ST_CHG_WAIT) && !tmo_end) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  // Pending counters and sticky overflow; FAULT swallows requests silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_pend <= 2'd0;
      chg_pend  <= 2'd0;
      overflow  <= 1'b0;
    end else if (ena) begin
      if (state == ST_FAULT) begin
        if (fault_clr) begin
          prod_pend <= 2'd0;
          chg_pend  <= 2'd0;
          overflow  <= 1'b0;
        end
      end else begin
        prod_pend <= pend_next(prod_pend, prod_req, prod_done);
        chg_pend  <= pend_next(chg_pend, chg_req, chg_done);
        if ((prod_req && !prod_done && prod_pend == 2'd3) ||
            (chg_req  && !chg_done  && chg_pend  == 2'd3)) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign uo_out  = {3'b000, overflow, fault, busy, chg_sol, prod_motor};
  assign uio_out = {4'b0000, chg_pend, prod_pend};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_vend_dispenser.sv
// Self-checking bench for tt_um_vend_dispenser: behavioural model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_tt_um_vend_dispenser;

  localparam int PULSE = 8;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  tt_um_vend_dispenser #(.PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 actuating, 2 awaiting drop, 3 fault; kind: 0 product, 1 change
  int m_phase = 0, m_kind = 0, m_t = 0, m_pp = 0, m_cp = 0;
  bit m_ovf = 0, m_seen = 0, m_pe, m_ce, m_dp, m_dc, m_was_fault, m_match;
  bit [2:0] m_hp = 3'b0, m_hc = 3'b0;   // raw sensor samples, newest in bit 0

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_kind = 0; m_t = 0; m_pp = 0; m_cp = 0;
      m_ovf = 0; m_seen = 0; m_hp = 3'b0; m_hc = 3'b0;
    end else if (ena) begin
      // a raw rise becomes visible to the controller two samples later
      m_pe = m_hp[1] & ~m_hp[2];
      m_ce = m_hc[1] & ~m_hc[2];
      m_hp = {m_hp[1:0], ui_in[2]};
      m_hc = {m_hc[1:0], ui_in[3]};
      m_dp = 0; m_dc = 0;
      m_was_fault = (m_phase == 3);
      m_match = (m_kind == 0) ? m_pe : m_ce;
      case (m_phase)
        0: begin
          if (m_pp > 0)      begin m_phase = 1; m_kind = 0; m_t = 0; m_seen = 0; end
          else if (m_cp > 0) begin m_phase = 1; m_kind = 1; m_t = 0; m_seen = 0; end
        end
        1: begin
          if (m_match) m_seen = 1;
          m_t = m_t + 1;
          if (m_t == PULSE) begin m_phase = 2; m_t = 0; end
        end
        2: begin
          if (m_seen || m_match) begin
            if (m_kind == 0) m_dp = 1; else m_dc = 1;
            m_phase = 0;
          end else begin
            m_t = m_t + 1;
            if (m_t == TMO) m_phase = 3;
          end
        end
        default: begin
          if (ui_in[4]) begin m_phase = 0; m_pp = 0; m_cp = 0; m_ovf = 0; end
        end
      endcase
      if (!m_was_fault) begin
        if (ui_in[0] && !m_dp) begin if (m_pp == 3) m_ovf = 1; else m_pp = m_pp + 1; end
        else if (m_dp && !ui_in[0]) m_pp = m_pp - 1;
        if (ui_in[1] && !m_dc) begin if (m_cp == 3) m_ovf = 1; else m_cp = m_cp + 1; end
        else if (m_dc && !ui_in[1]) m_cp = m_cp - 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  logic [7:0] exp_uo, exp_uio;
  always @(negedge clk) begin
    exp_uo  = {3'b000, m_ovf, (m_phase == 3), (m_phase != 0),
               (m_phase == 1 && m_kind == 1), (m_phase == 1 && m_kind == 0)};
    exp_uio = {4'b0000, 2'(m_cp), 2'(m_pp)};
    n_cmp++;
    if (uo_out !== exp_uo || uio_out !== exp_uio || uio_oe !== 8'h0F) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t uo_out=%h want %h uio_out=%h want %h uio_oe=%h want 0f",
               $time, uo_out, exp_uo, uio_out, exp_uio, uio_oe);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_uo(input int idx, input bit val, input int limit, output int cyc);
    cyc = 0;
    while (uo_out[idx] !== val && cyc < limit) begin
      tick();
      cyc++;
    end
    if (uo_out[idx] !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_uo[%0d]: got %0d, want %0d within %0d cycles", idx, uo_out[idx], val, limit);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int cyc, cnt, k;

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_uo_out", uo_out, 0);
    check("reset_uio_out", uio_out, 0);
    check("reset_uio_oe", uio_oe, 8'h0F);
    rst_n = 1'b1;
    tick();

    // Single product dispense, drop answered 3 cycles into the wait
    ui_in[0] = 1'b1; tick(); ui_in[0] = 1'b0;
    check("s1_pend_after_req", uio_out[1:0], 1);
    check("s1_motor_not_yet", uo_out[0], 0);
    tick();
    check("s1_motor_at_n_plus_2", uo_out[0], 1);
    cnt = 0;
    while (uo_out[0] === 1'b1 && cnt < 20) begin cnt++; tick(); end
    check("s1_motor_cycles", cnt, 8);
    tick(); tick();
    ui_in[2] = 1'b1;
    wait_uo(2, 1'b0, 20, cyc);
    check("s1_drop_to_idle_cycles", cyc, 3);
    check("s1_pend_cleared", uio_out[1:0], 0);
    check("s1_no_fault", uo_out[3], 0);
    ui_in[2] = 1'b0;
    tick();

    // Simultaneous product and change: product first, drop latched during drive
    ui_in[1:0] = 2'b11; tick(); ui_in[1:0] = 2'b00;
    check("s2_both_pending", uio_out, 8'h05);
    wait_uo(0, 1'b1, 10, cyc);
    check("s2_sol_off_during_motor", uo_out[1], 0);
    ui_in[2] = 1'b1; tick(); ui_in[2] = 1'b0;
    wait_uo(1, 1'b1, 40, cyc);
    check("s2_motor_off_during_sol", uo_out[0], 0);
    check("s2_prod_done_first", uio_out[1:0], 0);
    ui_in[3] = 1'b1; tick(); ui_in[3] = 1'b0;
    wait_uo(1, 1'b0, 20, cyc);
    check("s2_wait_first_cycle_busy", uo_out[2], 1);
    tick();
    check("s2_wait_done_in_one_cycle", uo_out[2], 0);
    check("s2_chg_pend_cleared", uio_out[3:2], 0);

    // Four product requests, no completion; fault_clr held but ignored outside FAULT
    ui_in[4] = 1'b1;
    ui_in[0] = 1'b1;
    repeat (3) tick();
    check("s3_pend_three", uio_out[1:0], 3);
    check("s3_no_overflow_yet", uo_out[4], 0);
    tick();
    ui_in[0] = 1'b0;
    ui_in[4] = 1'b0;
    check("s3_pend_saturated", uio_out[1:0], 3);
    check("s3_overflow_set", uo_out[4], 1);
    wait_uo(3, 1'b1, 200, cyc);
    check("s3_pend_kept_on_fault", uio_out[1:0], 3);
    ui_in[4] = 1'b1; tick(); ui_in[4] = 1'b0;
    check("s3_clear_uo", uo_out, 0);
    check("s3_clear_uio", uio_out, 0);

    // Change request never answered: timeout, ignored requests, clear
    ui_in[1] = 1'b1; tick(); ui_in[1] = 1'b0;
    wait_uo(1, 1'b1, 10, cyc);
    wait_uo(1, 1'b0, 20, cyc);
    k = 0;
    while (uo_out[3] !== 1'b1 && k < 100) begin
      if (k == 5) ui_in[2] = 1'b1;
      if (k == 7) ui_in[2] = 1'b0;
      tick();
      k++;
    end
    check("s4_timeout_cycles", k, 64);
    check("s4_chg_pend_kept", uio_out[3:2], 1);
    ui_in[1:0] = 2'b11; tick(); ui_in[1:0] = 2'b00;
    check("s4_req_in_fault_ignored", uio_out, 8'h04);
    check("s4_no_overflow_in_fault", uo_out[4], 0);
    ui_in[4] = 1'b1; tick(); ui_in[4] = 1'b0;
    check("s4_clear_uo", uo_out, 0);
    check("s4_clear_uio", uio_out, 0);

    // Reset in the 4th drive cycle
    ui_in[0] = 1'b1; tick(); ui_in[0] = 1'b0;
    wait_uo(0, 1'b1, 10, cyc);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("s5_motor_low_at_reset", uo_out[0], 0);
    check("s5_reset_uo", uo_out, 0);
    check("s5_reset_uio", uio_out, 0);
    check("s5_reset_oe", uio_oe, 8'h0F);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("s5_pending_lost", uio_out, 0);
    check("s5_idle_after_reset", uo_out, 0);

    // ena=0 freezes a dispense mid-drive
    ui_in[0] = 1'b1; tick(); ui_in[0] = 1'b0;
    wait_uo(0, 1'b1, 10, cyc);
    tick();
    ena = 1'b0;
    ui_in[1] = 1'b1;
    repeat (12) tick();
    check("s6_frozen_uo", uo_out, 8'h05);
    check("s6_frozen_uio", uio_out, 8'h01);
    ui_in[1] = 1'b0;
    ena = 1'b1;
    ui_in[2] = 1'b1; tick(); ui_in[2] = 1'b0;
    wait_uo(2, 1'b0, 40, cyc);
    check("s6_done_after_unfreeze", uio_out, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
